// File: rtl/wasm_stack_sched_pkg.sv
// Shared definitions for the WASM operand-stack sequencer: sizes, FSM state
// encoding, trap codes and the latched instruction payload.
package wasm_stack_sched_pkg;

  localparam int unsigned ST_WIDTH = 32;
  localparam int unsigned ST_DEPTH = 16;
  localparam int unsigned POP_MAX  = 3;
  localparam int unsigned DW       = $clog2(ST_DEPTH + 1);
  localparam int unsigned POP_W    = 2;
  localparam int unsigned ST_POP_W = 4;
  localparam int unsigned TRAP_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_TRAP   = 3'd4
  } state_e;

  localparam logic [TRAP_W-1:0] TRAP_NONE     = 2'd0;
  localparam logic [TRAP_W-1:0] TRAP_UNDER    = 2'd1;
  localparam logic [TRAP_W-1:0] TRAP_OVER     = 2'd2;
  localparam logic [TRAP_W-1:0] TRAP_MISMATCH = 2'd3;

  // Decoded instruction as held for the duration of its execution
  typedef struct packed {
    logic [POP_W-1:0]    pop;
    logic                push;
    logic                use_alu;
    logic [ST_WIDTH-1:0] imm;
  } instr_t;

endpackage

// File: rtl/wasm_stack_sched_if.sv
// Decode-to-sequencer instruction handshake.
//   req_valid/req_ready : valid/ready handshake
//   req_pop             : entries to pop (0..POP_MAX)
//   req_push            : instruction pushes one result
//   req_use_alu         : push data from ALU (1) or req_imm (0)
//   req_imm             : immediate push value
// master = decode stage, slave = sequencer.
interface wasm_stack_sched_if;
  import wasm_stack_sched_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [POP_W-1:0]    req_pop;
  logic                req_push;
  logic                req_use_alu;
  logic [ST_WIDTH-1:0] req_imm;

  modport master (
    output req_valid, req_pop, req_push, req_use_alu, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_pop, req_push, req_use_alu, req_imm,
    output req_ready
  );
endinterface

// File: rtl/wasm_stack_check.sv
// Combinational stack limit check, reusable by any stack sequencer.
//   depth      : current committed entry count
//   pop/push   : entries the instruction removes / adds
//   underflow  : pop exceeds depth
//   overflow   : result would exceed ST_DEPTH (only when no underflow)
//   depth_next : depth - pop + push (meaningful only when neither fault)
module wasm_stack_check
  import wasm_stack_sched_pkg::*;
(
  input  logic [DW-1:0]    depth,
  input  logic [POP_W-1:0] pop,
  input  logic             push,
  output logic             underflow,
  output logic             overflow,
  output logic [DW-1:0]    depth_next
);

  // One extra bit so neither the pop nor the push step can wrap
  localparam int unsigned CW = DW + 1;

  logic [CW-1:0] depth_x;
  logic [CW-1:0] after_pop;
  logic [CW-1:0] after_push;

  always_comb begin
    depth_x    = CW'(depth);
    underflow  = CW'(pop) > depth_x;
    after_pop  = depth_x - CW'(pop);
    after_push = after_pop + CW'(push);
    overflow   = !underflow && (after_push > CW'(ST_DEPTH));
    depth_next = after_push[DW-1:0];
  end

endmodule

// File: rtl/wasm_stack_sched.sv
// WASM operand-stack sequencer: accepts one decoded instruction at a time,
// checks it against its own depth counter, optionally runs the ALU, then
// commits the pop/push pair to the stack in a single cycle.
//   clk, rst_n    : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   req           : instruction handshake (slave side)
//   alu_start     : one-cycle ALU launch pulse
//   alu_done      : ALU result valid pulse, alu_result its data
//   st_push_num   : stack push control, st_pop_num stack pop count
//   st_push_data  : stack push data
//   st_empty      : stack empty flag, cross-checked against depth
//   depth         : committed entry count
//   busy          : sequencer not idle
//   trap/trap_code: sticky fault and its cause, cleared by trap_clr
module wasm_stack_sched
  import wasm_stack_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  wasm_stack_sched_if.slave   req,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [ST_WIDTH-1:0] alu_result,
  output logic                st_push_num,
  output logic [ST_POP_W-1:0] st_pop_num,
  output logic [ST_WIDTH-1:0] st_push_data,
  input  logic                st_empty,
  output logic [DW-1:0]       depth,
  output logic                busy,
  output logic                trap,
  output logic [TRAP_W-1:0]   trap_code,
  input  logic                trap_clr
);

  state_e              state, state_next;
  instr_t              instr, instr_d;
  logic                accept;
  logic                alu_capture;
  logic [ST_WIDTH-1:0] alu_q, alu_d, data_d;
  logic [TRAP_W-1:0]   code_d;
  logic                mismatch;

  logic [POP_W-1:0]    chk_pop;
  logic                chk_push;
  logic                chk_under, chk_over;
  logic [DW-1:0]       chk_depth_next;

  assign req.req_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign mismatch      = (depth == '0) != st_empty;

  // Check the incoming request while idle, the held instruction otherwise
  always_comb begin
    chk_pop  = instr.pop;
    chk_push = instr.push;
    if (state == S_IDLE) begin
      chk_pop  = req.req_pop;
      chk_push = req.req_push;
    end
  end

  wasm_stack_check u_check (
    .depth      (depth),
    .pop        (chk_pop),
    .push       (chk_push),
    .underflow  (chk_under),
    .overflow   (chk_over),
    .depth_next (chk_depth_next)
  );

  // Next state plus the values the output registers load
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    alu_capture = 1'b0;
    code_d      = trap_code;

    case (state)
      S_IDLE: begin
        // Depth/flag disagreement wins over a same-cycle request
        if (mismatch) begin
          state_next = S_TRAP;
          code_d     = TRAP_MISMATCH;
        end else if (req.req_valid) begin
          accept = 1'b1;
          if (chk_under) begin
            state_next = S_TRAP;
            code_d     = TRAP_UNDER;
          end else if (chk_over) begin
            state_next = S_TRAP;
            code_d     = TRAP_OVER;
          end else if (req.req_use_alu) begin
            state_next = S_EXEC;
          end else begin
            state_next = S_COMMIT;
          end
        end
      end
      S_EXEC, S_WAIT: begin
        if (alu_done) begin
          alu_capture = 1'b1;
          state_next  = S_COMMIT;
        end else begin
          state_next  = S_WAIT;
        end
      end
      S_COMMIT: state_next = S_IDLE;
      S_TRAP: begin
        if (trap_clr) begin
          state_next = S_IDLE;
          code_d     = TRAP_NONE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    instr_d = instr;
    if (accept) begin
      instr_d = '{pop: req.req_pop, push: req.req_push,
                  use_alu: req.req_use_alu, imm: req.req_imm};
    end
    alu_d  = alu_capture ? alu_result : alu_q;
    data_d = instr_d.use_alu ? alu_d : instr_d.imm;
  end

  // State register and held instruction/ALU result
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
      instr <= '0;
      alu_q <= '0;
      depth <= '0;
    end else begin
      state <= state_next;
      instr <= instr_d;
      alu_q <= alu_d;
      if (state == S_COMMIT) begin
        depth <= chk_depth_next;
      end
    end
  end

  // Registered outputs, loaded from the state being entered
  always_ff @(posedge clk) begin
    if (rst_n) begin
      alu_start    <= 1'b0;
      st_push_num  <= 1'b0;
      st_pop_num   <= '0;
      st_push_data <= '0;
      trap         <= 1'b0;
      trap_code    <= TRAP_NONE;
    end else begin
      alu_start <= (state_next == S_EXEC);
      trap      <= (state_next == S_TRAP);
      trap_code <= code_d;
      if (state_next == S_COMMIT) begin
        st_push_num  <= instr_d.push;
        st_pop_num   <= ST_POP_W'(instr_d.pop);
        st_push_data <= data_d;
      end else begin
        st_push_num  <= 1'b0;
        st_pop_num   <= '0;
        st_push_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wasm_stack_sched.sv
// Self-checking bench for wasm_stack_sched: directed scenarios plus random
// instructions, checked against an instruction-level stack model (a queue).
module tb_wasm_stack_sched;
  import wasm_stack_sched_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                alu_done = 1'b0;
  logic                trap_clr = 1'b0;
  logic                force_empty = 1'b0;
  logic                stk_empty = 1'b1;
  logic [ST_WIDTH-1:0] alu_result = '0;
  logic                alu_start, st_push_num, st_empty, busy, trap;
  logic [ST_POP_W-1:0] st_pop_num;
  logic [ST_WIDTH-1:0] st_push_data;
  logic [DW-1:0]       depth;
  logic [TRAP_W-1:0]   trap_code;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl[$];   // expected stack contents, top at the back
  logic [31:0] stk[$];   // stack device driven by the DUT's controls

  always #5 clk = ~clk;

  wasm_stack_sched_if rq();

  wasm_stack_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (rq),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .alu_result   (alu_result),
    .st_push_num  (st_push_num),
    .st_pop_num   (st_pop_num),
    .st_push_data (st_push_data),
    .st_empty     (st_empty),
    .depth        (depth),
    .busy         (busy),
    .trap         (trap),
    .trap_code    (trap_code),
    .trap_clr     (trap_clr)
  );

  // Operand stack device, reset together with the sequencer
  always @(posedge clk) begin
    if (rst_n) begin
      stk.delete();
      stk_empty <= 1'b1;
    end else begin
      for (int i = 0; i < int'(st_pop_num); i++)
        if (stk.size() > 0) void'(stk.pop_back());
      if (st_push_num) stk.push_back(st_push_data);
      stk_empty <= (stk.size() == 0);
    end
  end

  assign st_empty = force_empty | stk_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("clr_trap",  32'(trap), 0);
    chk("clr_code",  32'(trap_code), 0);
    chk("clr_ready", 32'(rq.req_ready), 1);
    chk("clr_depth", 32'(depth), 32'(mdl.size()));
  endtask

  // Issue one instruction and follow it to commit or to its trap
  task automatic do_instr(input int pop, input int push, input int use_alu,
                          input int lat, input logic [31:0] imm);
    int          d;
    int          code;
    logic [31:0] res;
    logic [31:0] data;
    d    = mdl.size();
    code = (pop > d) ? 1 : ((d - pop + push > int'(ST_DEPTH)) ? 2 : 0);
    res  = '0;
    if (use_alu != 0) begin
      if (pop == 0) res = $urandom;
      else if (pop <= d) for (int i = 0; i < pop; i++) res += mdl[d - 1 - i];
    end

    chk("issue_ready", 32'(rq.req_ready), 1);
    rq.req_valid   = 1'b1;
    rq.req_pop     = 2'(pop);
    rq.req_push    = 1'(push);
    rq.req_use_alu = 1'(use_alu);
    rq.req_imm     = imm;
    step();
    rq.req_valid   = 1'b0;

    if (code != 0) begin
      chk("fault_trap",  32'(trap), 1);
      chk("fault_code",  32'(trap_code), 32'(code));
      chk("fault_pop",   32'(st_pop_num), 0);
      chk("fault_push",  32'(st_push_num), 0);
      chk("fault_alu",   32'(alu_start), 0);
      alu_done = 1'b1;   // stray ALU completion while trapped
      step();
      alu_done = 1'b0;
      chk("trap_ready", 32'(rq.req_ready), 0);
      chk("trap_hold",  32'(trap_code), 32'(code));
      chk("trap_push",  32'(st_push_num), 0);
      step();
      chk("trap_sticky", 32'(trap), 1);
      do_clr();
      return;
    end

    if (use_alu != 0) begin
      chk("exec_start", 32'(alu_start), 1);
      chk("exec_pop",   32'(st_pop_num), 0);
      for (int k = 0; k <= lat; k++) begin
        if (k == lat) begin
          alu_done   = 1'b1;
          alu_result = res;
        end else begin
          alu_result = $urandom;
        end
        step();
        alu_done = 1'b0;
        if (k < lat) begin
          chk("wait_start", 32'(alu_start), 0);
          chk("wait_push",  32'(st_push_num), 0);
        end
      end
    end

    data = (use_alu != 0) ? res : imm;
    chk("commit_pop",  32'(st_pop_num), 32'(pop));
    chk("commit_push", 32'(st_push_num), 32'(push));
    if (push != 0) chk("commit_data", st_push_data, data);
    chk("commit_busy", 32'(busy), 1);
    for (int i = 0; i < pop; i++) void'(mdl.pop_back());
    if (push != 0) mdl.push_back(data);

    step();
    chk("post_pop",   32'(st_pop_num), 0);
    chk("post_push",  32'(st_push_num), 0);
    chk("post_data",  st_push_data, 0);
    chk("post_depth", 32'(depth), 32'(mdl.size()));
    chk("post_busy",  32'(busy), 0);
    if (mdl.size() > 0) chk("stack_top", stk[$], mdl[$]);
  endtask

  initial begin
    rq.req_valid   = 1'b0;
    rq.req_pop     = '0;
    rq.req_push    = 1'b0;
    rq.req_use_alu = 1'b0;
    rq.req_imm     = '0;

    // Reset values
    step();
    step();
    chk("rst_ready", 32'(rq.req_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_start", 32'(alu_start), 0);
    chk("rst_push",  32'(st_push_num), 0);
    chk("rst_pop",   32'(st_pop_num), 0);
    chk("rst_data",  st_push_data, 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_trap",  32'(trap), 0);
    chk("rst_code",  32'(trap_code), 0);
    rst_n = 1'b0;
    step();

    // Two immediates, then an ALU add with a 3-cycle ALU
    do_instr(0, 1, 0, 0, 32'd5);
    do_instr(0, 1, 0, 0, 32'd7);
    do_instr(2, 1, 1, 3, 32'd0);
    chk("add_result", mdl[$], 32'd12);

    // Underflow
    do_instr(2, 1, 0, 0, 32'd0);

    // Fill to capacity, overflow, then pop3/push1 at full
    while (mdl.size() < int'(ST_DEPTH)) do_instr(0, 1, 0, 0, $urandom);
    do_instr(0, 1, 0, 0, 32'd99);
    do_instr(3, 1, 1, 2, 32'd0);
    chk("full_p3_depth", 32'(depth), 14);

    // ALU done together with alu_start
    do_instr(2, 1, 1, 0, 32'd0);

    // Stray alu_done while idle
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("stray_busy",  32'(busy), 0);
    chk("stray_start", 32'(alu_start), 0);
    chk("stray_push",  32'(st_push_num), 0);
    chk("stray_depth", 32'(depth), 13);

    // No-op and ALU side-effect op without push
    do_instr(0, 0, 0, 0, 32'd1);
    do_instr(1, 0, 1, 1, 32'd0);

    // Random instructions
    for (int n = 0; n < 60; n++)
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), $urandom);

    // Reset while waiting on the ALU
    while (mdl.size() < 2) do_instr(0, 1, 0, 0, $urandom);
    chk("wrst_issue_ready", 32'(rq.req_ready), 1);
    rq.req_valid   = 1'b1;
    rq.req_pop     = 2'd1;
    rq.req_push    = 1'b1;
    rq.req_use_alu = 1'b1;
    step();
    rq.req_valid = 1'b0;
    chk("wrst_start", 32'(alu_start), 1);
    step();
    chk("wrst_wait_busy", 32'(busy), 1);
    rst_n = 1'b1;
    step();
    chk("wrst_busy",  32'(busy), 0);
    chk("wrst_push",  32'(st_push_num), 0);
    chk("wrst_pop",   32'(st_pop_num), 0);
    chk("wrst_depth", 32'(depth), 0);
    mdl.delete();
    rst_n = 1'b0;
    step();
    chk("wrst_idle_trap", 32'(trap), 0);

    // Depth/empty mismatch at depth 4 beats a same-cycle request
    for (int i = 0; i < 4; i++) do_instr(0, 1, 0, 0, $urandom);
    force_empty    = 1'b1;
    rq.req_valid   = 1'b1;
    rq.req_pop     = 2'd0;
    rq.req_push    = 1'b1;
    rq.req_use_alu = 1'b0;
    rq.req_imm     = 32'hdead;
    step();
    rq.req_valid = 1'b0;
    force_empty  = 1'b0;
    chk("mm_trap",  32'(trap), 1);
    chk("mm_code",  32'(trap_code), 3);
    chk("mm_push",  32'(st_push_num), 0);
    chk("mm_ready", 32'(rq.req_ready), 0);
    step();
    chk("mm_push2", 32'(st_push_num), 0);
    do_clr();
    chk("mm_top", stk[$], mdl[$]);

    // pop3/push1 at depth 3
    do_instr(1, 0, 0, 0, 32'd0);
    do_instr(3, 1, 1, 1, 32'd0);
    chk("p3_d3_depth", 32'(depth), 1);

    // trap_clr outside TRAP is ignored
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("idle_clr_busy",  32'(busy), 0);
    chk("idle_clr_depth", 32'(depth), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
